mips_regfile: RTL and testbench

Parametrised, clocked MIPS general-purpose register file with N read ports, one write port, optional write-to-read bypass, and a per-register busy scoreboard for pipeline hazard detection. It sits between the decode stage (reads, issue) and the write-back stage (writes). It replaces the combinational, fixed-width, 16-register file with a synchronous 32-entry array. Register 0 is hardwired to zero.

---
 rtl/mips_rf_pkg.sv | 30 +++
 rtl/mips_rf_read_port.sv | 42 ++++
 rtl/mips_regfile.sv | 84 ++++++++
 tb/tb_mips_regfile.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_rf_pkg.sv
// Shared definitions for the MIPS register file: default geometry and
// architectural register names used by decode logic and benches.
package mips_rf_pkg;

  localparam int RF_DATA_W   = 32'd32;
  localparam int RF_NUM_REGS = 32'd32;
  localparam int RF_ADDR_W   = 32'd5;

  localparam int REG_ZERO = 32'd0;

  localparam int T0 = 32'd8;
  localparam int T1 = 32'd9;
  localparam int T2 = 32'd10;
  localparam int T3 = 32'd11;
  localparam int T4 = 32'd12;
  localparam int T5 = 32'd13;
  localparam int T6 = 32'd14;
  localparam int T7 = 32'd15;
  localparam int S0 = 32'd16;
  localparam int S1 = 32'd17;
  localparam int S2 = 32'd18;
  localparam int S3 = 32'd19;
  localparam int S4 = 32'd20;
  localparam int S5 = 32'd21;
  localparam int S6 = 32'd22;
  localparam int S7 = 32'd23;
  localparam int SP = 32'd29;
  localparam int RA = 32'd31;

endpackage

// File: rtl/mips_rf_read_port.sv
// One combinational read port: r0 forcing, same-cycle write forwarding and
// selection of stored data plus its busy flag.
module mips_rf_read_port
  import mips_rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int BYPASS   = 32'd1
) (
  input  logic [ADDR_W-1:0]   raddr,
  input  logic [DATA_W-1:0]   regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] busy,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                rbusy
);

  logic bypass_hit_s;

  // A write landing this edge is also the value the consumer should see now
  assign bypass_hit_s = (BYPASS != 32'd0) && we && (waddr == raddr);

  // Port output selection: r0, forwarded write, or stored entry
  always_comb begin
    rdata = '0;
    rbusy = 1'b0;
    if (raddr == ADDR_W'(REG_ZERO)) begin
      rdata = '0;
      rbusy = 1'b0;
    end else if (bypass_hit_s) begin
      rdata = wdata;
      rbusy = 1'b0;
    end else begin
      rdata = regs[raddr];
      rbusy = busy[raddr];
    end
  end

endmodule

// File: rtl/mips_regfile.sv
// Synchronous MIPS register file with N read ports, one write port and a
// per-register busy scoreboard for decode-stage hazard detection.
module mips_regfile
  import mips_rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 32'd2,
  parameter int BYPASS   = 32'd1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     issue,
  input  logic [ADDR_W-1:0]        issue_dst,
  output logic                     any_busy
);

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [NUM_REGS-1:0] wr_clr_s;
  logic [NUM_REGS-1:0] iss_set_s;
  logic                any_busy_r;
  logic                wr_ok_s;
  logic                iss_ok_s;

  assign wr_ok_s  = we && (waddr != ADDR_W'(REG_ZERO));
  assign iss_ok_s = issue && (issue_dst != ADDR_W'(REG_ZERO));

  // Set applied after clear so a same-edge issue keeps the register busy
  assign wr_clr_s   = wr_ok_s  ? (NUM_REGS'(1) << waddr)     : '0;
  assign iss_set_s  = iss_ok_s ? (NUM_REGS'(1) << issue_dst) : '0;
  assign busy_nxt_s = ((busy_r & ~wr_clr_s) | iss_set_s) & ~NUM_REGS'(1);

  // Data array; entry 0 is never written and so stays zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_ok_s) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Busy scoreboard and its registered summary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= '0;
      any_busy_r <= 1'b0;
    end else begin
      busy_r     <= busy_nxt_s;
      any_busy_r <= |busy_nxt_s;
    end
  end

  assign any_busy = any_busy_r;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    mips_rf_read_port #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .ADDR_W  (ADDR_W),
      .BYPASS  (BYPASS)
    ) u_rd (
      .raddr(raddr[g*ADDR_W +: ADDR_W]),
      .regs (regs_r),
      .busy (busy_r),
      .we   (we),
      .waddr(waddr),
      .wdata(wdata),
      .rdata(rdata[g*DATA_W +: DATA_W]),
      .rbusy(rbusy[g])
    );
  end

endmodule

// File: tb/tb_mips_regfile.sv
// Self-checking bench for mips_regfile: directed vector table, reset corner
// sequence, and randomized traffic against an array-based reference model.
module tb_mips_regfile;
  import mips_rf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  ra0, ra1;
  logic [9:0]  raddr;
  logic        issue;
  logic [4:0]  issue_dst;
  logic [63:0] rdata, rdata_nb;
  logic [1:0]  rbusy, rbusy_nb;
  logic        any_busy, any_busy_nb;

  logic [31:0] mreg [32];
  logic        mbusy [32];
  int          total = 0;
  int          bad = 0;

  assign raddr = {ra1, ra0};

  always #5 clk = ~clk;

  mips_regfile #(.BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .issue(issue),
    .issue_dst(issue_dst), .any_busy(any_busy)
  );

  mips_regfile #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb), .issue(issue),
    .issue_dst(issue_dst), .any_busy(any_busy_nb)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra;
    logic        iss;
    logic [4:0]  dst;
    logic [31:0] exp_rd;
    logic        exp_rb;
    logic        exp_any;
    logic [31:0] exp_nb_rd;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && we && (waddr == a)) return wdata;
    return mreg[a];
  endfunction

  function automatic logic m_rb(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 1'b0;
    if (byp && we && (waddr == a)) return 1'b0;
    return mbusy[a];
  endfunction

  function automatic logic m_any();
    logic r = 1'b0;
    for (int i = 0; i < 32; i++) r = r | mbusy[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = 32'd0;
      mbusy[i] = 1'b0;
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic is, input logic [4:0] d);
    we = w; waddr = wa; wdata = wd; ra0 = a0; ra1 = a1; issue = is; issue_dst = d;
  endtask

  // Clock edge: advance the reference model with the inputs that were sampled
  task automatic tick();
    @(posedge clk);
    if (we && waddr != 5'd0) begin
      mreg[waddr]  = wdata;
      mbusy[waddr] = 1'b0;
    end
    if (issue && issue_dst != 5'd0) mbusy[issue_dst] = 1'b1;
    #1;
  endtask

  task automatic check_model();
    check("rd0",    rdata[31:0],     m_rd(ra0, 1'b1));
    check("rd1",    rdata[63:32],    m_rd(ra1, 1'b1));
    check("rb0",    rbusy[0],        m_rb(ra0, 1'b1));
    check("rb1",    rbusy[1],        m_rb(ra1, 1'b1));
    check("any",    any_busy,        m_any());
    check("nb_rd0", rdata_nb[31:0],  m_rd(ra0, 1'b0));
    check("nb_rd1", rdata_nb[63:32], m_rd(ra1, 1'b0));
    check("nb_rb0", rbusy_nb[0],     m_rb(ra0, 1'b0));
    check("nb_any", any_busy_nb,     m_any());
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    // {we, waddr, wdata, ra, iss, dst, exp_rd, exp_rb, exp_any, exp_nb_rd}
    vecs[0]  = '{1'b1, 5'(T0), 32'hDEADBEEF, 5'(T0), 1'b0, 5'd0,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,   32'h0,        5'(T0), 1'b0, 5'd0,  32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 5'd0,   32'h12345678, 5'd0,   1'b1, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 5'd0,   32'h0,        5'd0,   1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 5'd0,   32'h0,        5'(T1), 1'b1, 5'(T1), 32'h0,       1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 5'd0,   32'h0,        5'(T1), 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 5'(T1), 32'd5,        5'(T1), 1'b0, 5'd0,  32'd5,        1'b0, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 5'd0,   32'h0,        5'(T1), 1'b0, 5'd0,  32'd5,        1'b0, 1'b0, 32'd5};
    vecs[8]  = '{1'b1, 5'(T2), 32'd7,        5'(T2), 1'b1, 5'(T2), 32'd7,       1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 5'd0,   32'h0,        5'(T2), 1'b0, 5'd0,  32'd7,        1'b1, 1'b1, 32'd7};
    vecs[10] = '{1'b1, 5'(T2), 32'd1,        5'(T0), 1'b0, 5'd0,  32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[11] = '{1'b0, 5'd0,   32'h0,        5'(T2), 1'b0, 5'd0,  32'd1,        1'b0, 1'b0, 32'd1};

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    model_reset();
    #12;
    check("rst_any", any_busy, 1'b0);
    check("rst_rd0", rdata[31:0], 32'd0);
    rst_n = 1'b1;

    // Every index reads zero and idle right after reset
    for (int r = 0; r < 32; r++) begin
      ra0 = 5'(r);
      ra1 = 5'(31 - r);
      @(negedge clk);
      check("init_rd0", rdata[31:0], 32'd0);
      check("init_rd1", rdata[63:32], 32'd0);
      check("init_rb",  {30'd0, rbusy}, 32'd0);
      check("init_any", any_busy, 1'b0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].ra, vecs[i].ra,
            vecs[i].iss, vecs[i].dst);
      @(negedge clk);
      check("vec_rd0",    rdata[31:0],    vecs[i].exp_rd);
      check("vec_rd1",    rdata[63:32],   vecs[i].exp_rd);
      check("vec_rb0",    rbusy[0],       vecs[i].exp_rb);
      check("vec_any",    any_busy,       vecs[i].exp_any);
      check("vec_nb_rd0", rdata_nb[31:0], vecs[i].exp_nb_rd);
      tick();
    end

    // Issue r11, then reset mid-cycle: busy and data vanish at once
    drive(1'b0, 5'd0, 32'd0, 5'(T3), 5'(T0), 1'b1, 5'(T3));
    @(negedge clk);
    check("iss_same_cycle_rb", rbusy[0], 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'(T3), 5'(T0), 1'b0, 5'd0);
    @(negedge clk);
    check("iss_next_rb",  rbusy[0], 1'b1);
    check("iss_next_any", any_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_rb",  rbusy[0], 1'b0);
    check("mid_rst_any", any_busy, 1'b0);
    check("mid_rst_rd0", rdata[31:0], 32'd0);
    check("mid_rst_rd1", rdata[63:32], 32'd0);
    check("mid_rst_nb",  rdata_nb[63:32], 32'd0);
    drive(1'b1, 5'(T3), 32'h00000077, 5'(T3), 5'(T0), 1'b0, 5'd0);
    #1;
    rst_n = 1'b1;
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'(T3), 5'(T0), 1'b0, 5'd0);
    @(negedge clk);
    check("post_rst_wr",    rdata[31:0],    32'h00000077);
    check("post_rst_wr_nb", rdata_nb[31:0], 32'h00000077);
    check("post_rst_rb",    rbusy[0],       1'b0);
    tick();

    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom(), rnd_addr(), rnd_addr(),
            ($urandom_range(0, 2) == 0), rnd_addr());
      @(negedge clk);
      check_model();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
